// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg : shared widths and the writeback request type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;
  localparam int XLEN  = 32;
  localparam int REGW  = 5;
  localparam int NREGS = 32;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_req_t;
endpackage

`default_nettype wire

// File: rtl/regfile_wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo : synchronous buffer for secondary writeback results
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  wb_req_t push_data,
  input  logic    pop,
  output wb_req_t head,
  output logic    full,
  output logic    empty
);
  localparam int AW = $clog2(DEPTH);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_count_nxt;

  assign w_push      = push && !r_full;
  assign w_pop       = pop && !r_empty;
  assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);

  // DEPTH is a power of two, so plain pointer overflow is the wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

  assign head  = r_mem[r_rptr];
  assign full  = r_full;
  assign empty = r_empty;
endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : primary/secondary register-file write arbitration
// with starvation forcing and an outstanding-result scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             p_valid,
  input  logic [REGW-1:0]  p_rd,
  input  logic [XLEN-1:0]  p_data,
  output logic             p_ready,
  input  logic             s_valid,
  input  logic [REGW-1:0]  s_rd,
  input  logic [XLEN-1:0]  s_data,
  output logic             s_ready,
  input  logic             issue_valid,
  input  logic [REGW-1:0]  issue_rd,
  input  logic [REGW-1:0]  chk_rs1,
  input  logic [REGW-1:0]  chk_rs2,
  input  logic [REGW-1:0]  chk_rd,
  output logic             hazard,
  output logic             rf_we,
  output logic [REGW-1:0]  rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [NREGS-1:0] pending
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_STARVE_MAX = CW'(STARVE_MAX);

  wb_req_t          w_head;
  wb_req_t          w_push_req;
  logic             w_full;
  logic             w_empty;
  logic             w_force;
  logic             w_p_win;
  logic             w_head_grant;
  logic [NREGS-1:0] w_pending_nxt;
  logic [CW-1:0]    r_starve;
  logic [NREGS-1:0] r_pending;

  assign w_push_req = '{rd: s_rd, data: s_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s_valid),
    .push_data (w_push_req),
    .pop       (w_head_grant),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign w_force      = rst_n && !w_empty && (r_starve == C_STARVE_MAX);
  assign w_p_win      = rst_n && p_valid && (p_rd != '0) && !w_force;
  assign w_head_grant = rst_n && !w_empty && (w_force || !(p_valid && (p_rd != '0)));

  assign p_ready = rst_n && !w_force;
  assign s_ready = rst_n && !w_full;

  // x0 requests are consumed silently, so only nonzero targets raise rf_we
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (w_p_win) begin
      rf_we    = 1'b1;
      rf_waddr = p_rd;
      rf_wdata = p_data;
    end else if (w_head_grant && (w_head.rd != '0)) begin
      rf_we    = 1'b1;
      rf_waddr = w_head.rd;
      rf_wdata = w_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_empty || w_head_grant) begin
      r_starve <= '0;
    end else if (r_starve != C_STARVE_MAX) begin
      r_starve <= r_starve + CW'(1);
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_head_grant && (w_head.rd != '0)) w_pending_nxt[w_head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0))   w_pending_nxt[issue_rd]  = 1'b1;
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_pending <= '0;
    else        r_pending <= w_pending_nxt;
  end

  assign pending = r_pending;
  assign hazard  = r_pending[chk_rs1] | r_pending[chk_rs2] | r_pending[chk_rd];
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter : directed self-checking bench for regfile_wb_arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        p_ready;
  logic        s_valid;
  logic [4:0]  s_rd;
  logic [31:0] s_data;
  logic        s_ready;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p_valid     (p_valid),
    .p_rd        (p_rd),
    .p_data      (p_data),
    .p_ready     (p_ready),
    .s_valid     (s_valid),
    .s_rd        (s_rd),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_rd      (chk_rd),
    .hazard      (hazard),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .pending     (pending)
  );

  // Inputs change at negedge; checks run 1ns later, far from the posedge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h1111;
    s_valid = 1'b1; s_rd = 5'd4; s_data = 32'h2222;
    issue_valid = 1'b1; issue_rd = 5'd6;
    chk_rs1 = 5'd6; chk_rs2 = 5'd0; chk_rd = 5'd0;
    step(); step();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL reset_p_ready: got %b want 0", p_ready); end
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %0d/%h want 0/0", rf_waddr, rf_wdata); end
    n_checks++; if (pending !== 32'd0 || hazard !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %h/%b want 0/0", pending, hazard); end
    @(negedge clk);
    p_valid = 1'b0; s_valid = 1'b0; issue_valid = 1'b0; rst_n = 1'b1;
    #1;
    n_checks++; if (p_ready !== 1'b1 || s_ready !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("FAIL post_reset_ready: got p%b s%b we%b want 1 1 0", p_ready, s_ready, rf_we); end
  endtask

  task automatic test_basic_writeback();
    @(negedge clk); issue_valid = 1'b1; issue_rd = 5'd5; chk_rs1 = 5'd5;
    step();
    issue_valid = 1'b0; s_valid = 1'b1; s_rd = 5'd5; s_data = 32'hDEADBEEF;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL basic_hazard_pre: got %b want 1", hazard); end
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL basic_no_early_write: got %b want 0", rf_we); end
    step();
    s_valid = 1'b0; #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_write: got %b/%0d/%h want 1/5/deadbeef", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (hazard !== 1'b1 || pending[5] !== 1'b1) begin n_fail++; $display("FAIL basic_no_forward: got %b/%b want 1/1", hazard, pending[5]); end
    step();
    n_checks++; if (pending[5] !== 1'b0 || hazard !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL basic_cleared: got %b/%b/%b want 0/0/0", pending[5], hazard, rf_we); end
    chk_rs1 = 5'd0;
  endtask

  task automatic test_starvation();
    p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h33;
    s_valid = 1'b1; s_rd = 5'd7; s_data = 32'h77;
    #1;
    n_checks++; if (rf_waddr !== 5'd3 || p_ready !== 1'b1) begin n_fail++; $display("FAIL starve_push_cycle: got %0d/%b want 3/1", rf_waddr, p_ready); end
    step();
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || p_ready !== 1'b1) begin n_fail++; $display("FAIL starve_blocked_%0d: got %b/%0d/%b want 1/3/1", k, rf_we, rf_waddr, p_ready); end
      step();
    end
    n_checks++; if (p_ready !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h77) begin n_fail++; $display("FAIL starve_forced: got %b/%0d/%h want 0/7/77", p_ready, rf_waddr, rf_wdata); end
    step();
    n_checks++; if (p_ready !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h33) begin n_fail++; $display("FAIL starve_after: got %b/%0d/%h want 1/3/33", p_ready, rf_waddr, rf_wdata); end
    p_valid = 1'b0;
  endtask

  task automatic test_fill_and_wrap();
    p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h33;
    s_valid = 1'b1; s_rd = 5'd10; s_data = 32'hA0;
    step();
    s_rd = 5'd11; s_data = 32'hB0;
    step();
    s_rd = 5'd12; s_data = 32'hC0;
    #1;
    n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: got %b want 0", s_ready); end
    step();
    n_checks++; if (s_ready !== 1'b0 || rf_waddr !== 5'd3) begin n_fail++; $display("FAIL fill_hold: got %b/%0d want 0/3", s_ready, rf_waddr); end
    p_valid = 1'b0; s_valid = 1'b0; #1;
    n_checks++; if (rf_waddr !== 5'd10 || rf_wdata !== 32'hA0) begin n_fail++; $display("FAIL fill_drain0: got %0d/%h want 10/a0", rf_waddr, rf_wdata); end
    step();
    n_checks++; if (rf_waddr !== 5'd11 || rf_wdata !== 32'hB0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_drain1: got %0d/%h/%b want 11/b0/1", rf_waddr, rf_wdata, s_ready); end
    step();
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL fill_third_dropped: got %b want 0", rf_we); end
    for (int i = 0; i < 6; i++) begin
      s_valid = (i < 5); s_rd = 5'(16 + i); s_data = 32'h100 + 32'(i);
      #1;
      if (i == 0) begin
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL wrap_idle: got %b want 0", rf_we); end
      end else begin
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(15 + i) || rf_wdata !== 32'hFF + 32'(i)) begin n_fail++; $display("FAIL wrap_%0d: got %b/%0d/%h want 1/%0d/%h", i, rf_we, rf_waddr, rf_wdata, 15 + i, 32'hFF + 32'(i)); end
      end
      step();
    end
    s_valid = 1'b0;
  endtask

  task automatic test_set_clear_same_cycle();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0; s_valid = 1'b1; s_rd = 5'd9; s_data = 32'h99;
    step();
    s_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd9; #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin n_fail++; $display("FAIL same_write: got %b/%0d want 1/9", rf_we, rf_waddr); end
    step();
    issue_valid = 1'b0; #1;
    n_checks++; if (pending[9] !== 1'b1) begin n_fail++; $display("FAIL same_set_wins: got %b want 1", pending[9]); end
  endtask

  task automatic test_null_primary();
    p_valid = 1'b1; p_rd = 5'd0; p_data = 32'hFFFF;
    s_valid = 1'b1; s_rd = 5'd12; s_data = 32'hC12; #1;
    n_checks++; if (rf_we !== 1'b0 || p_ready !== 1'b1) begin n_fail++; $display("FAIL null_no_write: got %b/%b want 0/1", rf_we, p_ready); end
    step();
    s_valid = 1'b1; s_rd = 5'd0; s_data = 32'h5A; #1;
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC12 || p_ready !== 1'b1) begin n_fail++; $display("FAIL null_head_written: got %b/%0d/%h/%b want 1/12/c12/1", rf_we, rf_waddr, rf_wdata, p_ready); end
    step();
    s_valid = 1'b1; s_rd = 5'd13; s_data = 32'hD13; #1;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL null_secondary_x0: got %b want 0", rf_we); end
    step();
    s_valid = 1'b0; #1;
    n_checks++; if (rf_waddr !== 5'd13 || rf_wdata !== 32'hD13) begin n_fail++; $display("FAIL null_x0_consumed: got %0d/%h want 13/d13", rf_waddr, rf_wdata); end
    step();
    p_valid = 1'b0;
  endtask

  task automatic test_reset_mid_operation();
    issue_valid = 1'b1; issue_rd = 5'd5;
    p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h33;
    s_valid = 1'b1; s_rd = 5'd20; s_data = 32'h20;
    step();
    issue_valid = 1'b0; s_rd = 5'd21; s_data = 32'h21;
    step();
    s_valid = 1'b0; #1;
    n_checks++; if (pending !== 32'h0000_0220 || s_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_setup: got %h/%b want 00000220/0", pending, s_ready); end
    rst_n = 1'b0; #1;
    n_checks++; if (rf_we !== 1'b0 || p_ready !== 1'b0 || s_ready !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL midrst_outputs: got %b%b%b/%0d/%h want 000/0/0", rf_we, p_ready, s_ready, rf_waddr, rf_wdata); end
    step();
    rst_n = 1'b1; p_valid = 1'b0; chk_rs1 = 5'd5; chk_rs2 = 5'd9; #1;
    n_checks++; if (pending !== 32'd0 || hazard !== 1'b0 || s_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cleared: got %h/%b/%b want 0/0/1", pending, hazard, s_ready); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_no_write_%0d: got %b want 0", k, rf_we); end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_writeback();
    test_starvation();
    test_fill_and_wrap();
    test_set_clear_same_cycle();
    test_null_primary();
    test_reset_mid_operation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
